// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width and default bit timing.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to RESET_VAL.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic res,
  input  logic raw,
  output logic synced
);

  logic meta;

  always_ff @(posedge clk) begin
    if (res) begin
      meta   <= RESET_VAL;
      synced <= RESET_VAL;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, with a one-entry holding register (valid/rd handshake).
// Define UART_RX_PARITY_EN to receive an even-parity bit and add the parityErr output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT  // even and >= 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic       serialIn,
  output logic [7:0] data,
  output logic       valid,
  input  logic       rd,
  output logic       overrun,
  output logic       frameErr
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parityErr
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  // Three consecutive highs outlast the synchronizer's reset value, so a line
  // held low through reset cannot masquerade as an idle line.
  localparam logic [CNT_W-1:0] CNT_HIGH_OK = CNT_W'(2);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rxd;
  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                      par_bit;
`endif

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .res    (res),
    .raw    (serialIn),
    .synced (rxd)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= WAIT_HIGH;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      data     <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      parityErr <= 1'b0;
`endif
    end else begin
      frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr <= 1'b0;
`endif
      if (rd && valid) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end

      case (state)
        WAIT_HIGH: begin
          if (!rxd) begin
            cnt <= '0;
          end else if (cnt == CNT_HIGH_OK) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        IDLE: begin
          if (!rxd) begin
            cnt   <= '0;
            state <= START;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxd) begin
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt             <= '0;
            shift[bit_idx]  <= rxd;
            bit_idx         <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rxd;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!rxd) begin
              frameErr <= 1'b1;
              state    <= WAIT_HIGH;
            end else begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bit != even_parity(shift)) begin
                parityErr <= 1'b1;
              end else
`endif
              // A read on the delivery edge frees the register for the new byte.
              if (!valid || rd) begin
                data  <= shift;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cnt   <= '0;
          state <= WAIT_HIGH;
        end
      endcase
    end
  end

endmodule
